// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one latency-tolerant memory port between the instruction-fetch
// requester and the data (load/store) requester. One transaction is outstanding at a
// time: IDLE (arbitrate, capture) -> ISSUE (req/ready handshake) -> WAIT (response)
// -> RESP (one-cycle pulse to the owner) -> IDLE.
//
// Parameters:
//   DATA_PRIO  1: data wins contention in IDLE, 0: fetch wins (fixed-priority build)
//   TIMEOUT    cycles allowed in ISSUE+WAIT before aborting with err; 0 disables
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, contention is resolved in favour of the requester
//                       not granted last (1-bit last-owner register, resets to fetch)
//                       and DATA_PRIO is ignored.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_if_req/i_if_addr                fetch request and byte address
//   o_if_gnt                          fetch request captured this cycle (combinational)
//   o_if_rvalid/o_if_rdata/o_if_err   fetch response pulse, instruction word, timeout flag
//   i_d_req/i_d_wen/i_d_addr          data request, store select, byte address
//   i_d_wdata/i_d_mask                store data (lane-shifted) and byte-lane mask
//   o_d_gnt                           data request captured this cycle (combinational)
//   o_d_rvalid/o_d_rdata/o_d_err      data response pulse, load word (0 for stores), timeout
//   o_mem_req/o_mem_wen/o_mem_addr    memory request, write select, word-aligned address
//   o_mem_wdata/o_mem_mask            memory write data and byte mask
//   i_mem_ready                       memory accepts when o_mem_req && i_mem_ready
//   i_mem_rvalid/i_mem_rdata          memory response and read data
module mem_arbiter #(
    parameter int unsigned DATA_PRIO = 1,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    output logic        o_if_err,

    input  logic        i_d_req,
    input  logic        i_d_wen,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [3:0]  i_d_mask,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic [31:0] o_d_rdata,
    output logic        o_d_err,

    output logic        o_mem_req,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    localparam int unsigned DW    = 32;
    localparam int unsigned WAW   = 30;
    localparam int unsigned MW    = 4;
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               wen_q, wen_d;
    logic [WAW-1:0]     addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [MW-1:0]      mask_q, mask_d;
    logic               mem_req_q, mem_req_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               if_rvalid_q, if_rvalid_d;
    logic [DW-1:0]      if_rdata_q, if_rdata_d;
    logic               if_err_q, if_err_d;
    logic               d_rvalid_q, d_rvalid_d;
    logic [DW-1:0]      d_rdata_q, d_rdata_d;
    logic               d_err_q, d_err_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic               last_owner_q, last_owner_d;
`endif

    logic               pick_data_c;
    logic               idle_c;
    logic               d_gnt_c;
    logic               if_gnt_c;
    logic               timeout_hit_c;
    logic               resp_fire_c;
    logic               resp_err_c;
    logic [DW-1:0]      resp_data_c;

    // Memory is word-addressed; byte offsets are carried by the mask.
    logic [3:0]         unused_addr_bits;
    assign unused_addr_bits = {i_if_addr[1:0], i_d_addr[1:0]};

    // Arbitration: grant only in IDLE, never both, never while reset is asserted.
    always_comb begin
        pick_data_c = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        pick_data_c = i_d_req && (!i_if_req || (last_owner_q == OWN_IF));
`else
        pick_data_c = i_d_req && (!i_if_req || (DATA_PRIO != 0));
`endif
        idle_c   = (state_q == S_IDLE) && !i_rst;
        d_gnt_c  = idle_c && pick_data_c;
        if_gnt_c = idle_c && i_if_req && !pick_data_c;
    end

    // The TIMEOUT-th cycle spent in ISSUE/WAIT aborts the transaction.
    always_comb begin
        timeout_hit_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    // Next-state and response logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        mem_req_d   = mem_req_q;
        cnt_d       = cnt_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = '0;
        if_err_d    = 1'b0;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = '0;
        d_err_d     = 1'b0;
        resp_fire_c = 1'b0;
        resp_err_c  = 1'b0;
        resp_data_c = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (d_gnt_c) begin
                    owner_d = OWN_D;
                    wen_d   = i_d_wen;
                    addr_d  = i_d_addr[31:2];
                    wdata_d = i_d_wdata;
                    mask_d  = i_d_mask;
                end else if (if_gnt_c) begin
                    owner_d = OWN_IF;
                    wen_d   = 1'b0;
                    addr_d  = i_if_addr[31:2];
                    wdata_d = '0;
                    mask_d  = 4'b1111;
                end
                if (d_gnt_c || if_gnt_c) begin
                    cnt_d     = '0;
                    mem_req_d = 1'b1;
                    state_d   = S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = d_gnt_c ? OWN_D : OWN_IF;
`endif
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An accept on the abort cycle is dropped; its response lands in IDLE.
                if (timeout_hit_c) begin
                    mem_req_d   = 1'b0;
                    resp_fire_c = 1'b1;
                    resp_err_c  = 1'b1;
                end else if (i_mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A real response on the abort cycle is preferred over the error.
                if (i_mem_rvalid) begin
                    resp_fire_c = 1'b1;
                    resp_data_c = wen_q ? '0 : i_mem_rdata;
                end else if (timeout_hit_c) begin
                    resp_fire_c = 1'b1;
                    resp_err_c  = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // Response outputs are loaded on entry to RESP, so they pulse for one cycle.
        if (resp_fire_c) begin
            state_d = S_RESP;
            if (owner_q == OWN_D) begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = resp_data_c;
                d_err_d    = resp_err_c;
            end else begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = resp_data_c;
                if_err_d    = resp_err_c;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            mem_req_q   <= 1'b0;
            cnt_q       <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= OWN_IF;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            mem_req_q   <= mem_req_d;
            cnt_q       <= cnt_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign o_if_gnt    = if_gnt_c;
    assign o_d_gnt     = d_gnt_c;
    assign o_if_rvalid = if_rvalid_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_if_err    = if_err_q;
    assign o_d_rvalid  = d_rvalid_q;
    assign o_d_rdata   = d_rdata_q;
    assign o_d_err     = d_err_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_wen   = wen_q;
    assign o_mem_addr  = {addr_q, 2'b00};
    assign o_mem_wdata = wdata_q;
    assign o_mem_mask  = mask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter (DATA_PRIO=1, TIMEOUT=8).
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_mask;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(
        .DATA_PRIO (1),
        .TIMEOUT   (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_if_req     (if_req),
        .i_if_addr    (if_addr),
        .o_if_gnt     (if_gnt),
        .o_if_rvalid  (if_rvalid),
        .o_if_rdata   (if_rdata),
        .o_if_err     (if_err),
        .i_d_req      (d_req),
        .i_d_wen      (d_wen),
        .i_d_addr     (d_addr),
        .i_d_wdata    (d_wdata),
        .i_d_mask     (d_mask),
        .o_d_gnt      (d_gnt),
        .o_d_rvalid   (d_rvalid),
        .o_d_rdata    (d_rdata),
        .o_d_err      (d_err),
        .o_mem_req    (mem_req),
        .o_mem_wen    (mem_wen),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_mask   (mem_mask),
        .i_mem_ready  (mem_ready),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance past the next active edge before driving inputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int          ng;
        logic        both;
        logic [3:0]  seq;
        logic [3:0]  seq_exp;

        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b0; d_wen = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_mask = 4'h0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Reset: no grant even with a pending request, all outputs low.
        @(negedge clk);
        chk("rst_if_gnt",  32'(if_gnt),  32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        step(); if_req = 1'b0;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("idle_mem_req",   32'(mem_req),   32'h0);
        chk("idle_if_rvalid", 32'(if_rvalid), 32'h0);
        chk("idle_d_rvalid",  32'(d_rvalid),  32'h0);
        chk("idle_d_gnt",     32'(d_gnt),     32'h0);

        // Fetch 0x104, response after two idle WAIT cycles.
        step(); if_req = 1'b1; if_addr = 32'h0000_0104;
        @(negedge clk);
        chk("t1_if_gnt", 32'(if_gnt), 32'h1);
        chk("t1_d_gnt",  32'(d_gnt),  32'h0);
        step(); if_req = 1'b0; if_addr = 32'hFFFF_FFF0; mem_ready = 1'b1;
        @(negedge clk);
        chk("t1_mem_req",  32'(mem_req),  32'h1);
        chk("t1_mem_addr", mem_addr,      32'h0000_0104);
        chk("t1_mem_mask", 32'(mem_mask), 32'hF);
        chk("t1_mem_wen",  32'(mem_wen),  32'h0);
        step(); mem_ready = 1'b0;
        @(negedge clk);
        chk("t1_req_drop", 32'(mem_req), 32'h0);
        step();
        step(); mem_rvalid = 1'b1; mem_rdata = 32'h0010_0073;
        step(); mem_rvalid = 1'b0;
        @(negedge clk);
        chk("t1_if_rvalid", 32'(if_rvalid), 32'h1);
        chk("t1_if_rdata",  if_rdata,       32'h0010_0073);
        chk("t1_if_err",    32'(if_err),    32'h0);
        chk("t1_d_rvalid",  32'(d_rvalid),  32'h0);
        step();
        @(negedge clk);
        chk("t1_pulse_end", 32'(if_rvalid), 32'h0);

        // Contention with DATA_PRIO=1: data first, fetch in the next IDLE.
        step();
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_3004; d_mask = 4'hF;
        if_req = 1'b1; if_addr = 32'h0000_0200;
        @(negedge clk);
        chk("t2_d_gnt",  32'(d_gnt),  32'h1);
        chk("t2_if_gnt", 32'(if_gnt), 32'h0);
        step(); d_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("t2_mem_addr", mem_addr,       32'h0000_3004);
        chk("t2_busy_gnt", 32'(if_gnt),    32'h0);
        step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step(); mem_rvalid = 1'b0;
        @(negedge clk);
        chk("t2_d_rvalid",  32'(d_rvalid),  32'h1);
        chk("t2_d_rdata",   d_rdata,        32'hDEAD_BEEF);
        chk("t2_if_rvalid", 32'(if_rvalid), 32'h0);
        chk("t2_resp_gnt",  32'(if_gnt),    32'h0);
        step();
        @(negedge clk);
        chk("t2_if_gnt_next", 32'(if_gnt), 32'h1);
        step(); if_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("t2_fetch_addr", mem_addr, 32'h0000_0200);
        step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        step(); mem_rvalid = 1'b0;
        @(negedge clk);
        chk("t2_if_rvalid2", 32'(if_rvalid), 32'h1);
        chk("t2_if_rdata2",  if_rdata,       32'h0000_0013);
        step();

        // Store with ready held low for three cycles; ack returns rdata 0.
        step();
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h0000_2003; d_mask = 4'b1000;
        d_wdata = 32'hAB00_0000; mem_ready = 1'b0;
        @(negedge clk);
        chk("t3_d_gnt", 32'(d_gnt), 32'h1);
        step(); d_req = 1'b0; d_wen = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_mask = 4'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_hold_req",   32'(mem_req),   32'h1);
            chk("t3_hold_addr",  mem_addr,       32'h0000_2000);
            chk("t3_hold_wen",   32'(mem_wen),   32'h1);
            chk("t3_hold_wdata", mem_wdata,      32'hAB00_0000);
            chk("t3_hold_mask",  32'(mem_mask),  32'h8);
            step();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t3_req_ready", 32'(mem_req), 32'h1);
        step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        step(); mem_rvalid = 1'b0;
        @(negedge clk);
        chk("t3_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("t3_d_rdata",  d_rdata,       32'h0);
        chk("t3_d_err",    32'(d_err),    32'h0);
        step();

        // Timeout: memory accepts but never responds.
        step(); d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_0040; d_mask = 4'hF;
        @(negedge clk);
        chk("t4_d_gnt", 32'(d_gnt), 32'h1);
        step(); d_req = 1'b0; mem_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(); mem_ready = 1'b0;
            @(negedge clk);
            if (k < 8) chk("t4_no_resp", 32'(d_rvalid), 32'h0);
        end
        chk("t4_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("t4_d_err",    32'(d_err),    32'h1);
        chk("t4_d_rdata",  d_rdata,       32'h0);
        chk("t4_mem_req",  32'(mem_req), 32'h0);
        step(); mem_rvalid = 1'b1; mem_rdata = 32'h0000_0099;
        @(negedge clk);
        chk("t4_stray_d", 32'(d_rvalid), 32'h0);
        step(); mem_rvalid = 1'b0;
        @(negedge clk);
        chk("t4_stray_d2",  32'(d_rvalid),  32'h0);
        chk("t4_stray_if",  32'(if_rvalid), 32'h0);
        chk("t4_stray_req", 32'(mem_req),   32'h0);

        // Reset while in WAIT, followed by a late response.
        step(); if_req = 1'b1; if_addr = 32'h0000_0500;
        @(negedge clk);
        chk("t5_if_gnt", 32'(if_gnt), 32'h1);
        step(); if_req = 1'b0; mem_ready = 1'b1;
        step(); mem_ready = 1'b0;
        step(); rst = 1'b1;
        step(); rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0777;
        @(negedge clk);
        chk("t5_mem_req",   32'(mem_req),   32'h0);
        chk("t5_if_rvalid", 32'(if_rvalid), 32'h0);
        step(); mem_rvalid = 1'b0;
        @(negedge clk);
        chk("t5_if_rvalid2", 32'(if_rvalid), 32'h0);
        chk("t5_d_rvalid",   32'(d_rvalid),  32'h0);

        // Both requesters held high: record the first four grants.
`ifdef ARB_ROUND_ROBIN_EN
        seq_exp = 4'b0101;
`else
        seq_exp = 4'b1111;
`endif
        ng = 0; both = 1'b0; seq = 4'b0;
        step();
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_0800; d_mask = 4'hF;
        if_req = 1'b1; if_addr = 32'h0000_0900;
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (d_gnt && if_gnt) both = 1'b1;
            if (d_gnt || if_gnt) begin
                seq[ng] = d_gnt;
                ng++;
            end
        end
        step(); d_req = 1'b0; if_req = 1'b0;
        repeat (4) step();
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        chk("t6_grant_cnt",  32'(ng),   32'd4);
        chk("t6_grant_seq",  32'(seq),  32'(seq_exp));
        chk("t6_double_gnt", 32'(both), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
